// File: rtl/pipelined_control_unit_pkg.sv
// Shared opcode constants, control encodings and the ID/EX control bundle type.
// No logic here: types and constants only.
package pipelined_control_unit_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_RFN = 2'b10,
    ALU_IFN = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_sel_t;

  typedef struct packed {
    logic     branch;
    logic     jump;
    logic     mem_read;
    logic     mem_to_reg;
    logic     mem_write;
    logic     alu_src;
    logic     reg_write;
    alu_op_t  alu_op;
    imm_sel_t imm_sel;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// ID-stage inputs and ID/EX outputs of the control unit, grouped as one bus.
// master drives the ID side and observes EX; slave is the control unit itself.
interface pipelined_control_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [31:0]       id_instr;
  logic              ex_flush;
  logic              ex_hold;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch;
  logic              ex_jump;
  logic              ex_mem_read;
  logic              ex_mem_to_reg;
  logic              ex_mem_write;
  logic              ex_alu_src;
  logic              ex_reg_write;
  logic [1:0]        ex_alu_op;
  logic [2:0]        ex_imm_sel;
  logic              pc_write;
  logic              ifid_write;
  logic              illegal;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_instr, ex_flush, ex_hold,
    input  ex_valid, ex_rd, ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op, ex_imm_sel,
           pc_write, ifid_write, illegal, stall_count
  );

  modport slave (
    input  id_valid, id_instr, ex_flush, ex_hold,
    output ex_valid, ex_rd, ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op, ex_imm_sel,
           pc_write, ifid_write, illegal, stall_count
  );
endinterface

// File: rtl/pipelined_control_unit_opcode_decoder.sv
// Combinational RV32I opcode decoder: control bundle, illegal flag, rs usage.
// Latency 0; no backpressure.
module opcode_decoder
  import pipelined_control_unit_pkg::*;
#(
  parameter bit ENABLE_JUMP  = 1'b1,
  parameter bit ENABLE_ITYPE = 1'b1
) (
  input  logic [6:0]   i_opcode,
  output ctrl_bundle_t o_ctrl,
  output logic         o_illegal,
  output logic         o_use_rs1,
  output logic         o_use_rs2
);

  always_comb begin
    o_ctrl    = CTRL_NOP;
    o_illegal = 1'b0;
    o_use_rs1 = 1'b0;
    o_use_rs2 = 1'b0;
    case (i_opcode)
      OP_R: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_RFN;
        o_use_rs1        = 1'b1;
        o_use_rs2        = 1'b1;
      end
      OP_IMM: begin
        if (ENABLE_ITYPE) begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALU_IFN;
          o_ctrl.imm_sel   = IMM_I;
          o_use_rs1        = 1'b1;
        end else o_illegal = 1'b1;
      end
      OP_LOAD: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.imm_sel    = IMM_I;
        o_use_rs1         = 1'b1;
      end
      OP_STORE: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.imm_sel   = IMM_S;
        o_use_rs1        = 1'b1;
        o_use_rs2        = 1'b1;
      end
      OP_BRANCH: begin
        o_ctrl.branch  = 1'b1;
        o_ctrl.alu_op  = ALU_SUB;
        o_ctrl.imm_sel = IMM_B;
        o_use_rs1      = 1'b1;
        o_use_rs2      = 1'b1;
      end
      OP_JAL: begin
        if (ENABLE_JUMP) begin
          o_ctrl.jump      = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.imm_sel   = IMM_J;
        end else o_illegal = 1'b1;
      end
      OP_JALR: begin
        if (ENABLE_JUMP) begin
          o_ctrl.jump      = 1'b1;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.imm_sel   = IMM_I;
          o_use_rs1        = 1'b1;
        end else o_illegal = 1'b1;
      end
      OP_LUI: begin
        if (ENABLE_ITYPE) begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.imm_sel   = IMM_U;
        end else o_illegal = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage control: decodes into the ID/EX register, inserts load-use bubbles. Latency 1 cycle.
// Backpressure: ex_hold freezes ID/EX and stalls PC/IF-ID; ex_flush overrides both hold and hazard.
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter bit ENABLE_JUMP  = 1'b1,
  parameter bit ENABLE_ITYPE = 1'b1,
  parameter int CNT_W        = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  pipelined_control_unit_if.slave bus
);

  ctrl_bundle_t      w_ctrl;
  logic              w_illegal;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic              w_hazard;
  logic              w_stall;
  logic              w_unused_bits;

  ctrl_bundle_t      r_ctrl;
  logic              r_valid;
  logic [REG_AW-1:0] r_rd;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_stall_cnt;

  opcode_decoder #(
    .ENABLE_JUMP  (ENABLE_JUMP),
    .ENABLE_ITYPE (ENABLE_ITYPE)
  ) u_dec (
    .i_opcode  (bus.id_instr[6:0]),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );

  assign w_rs1 = bus.id_instr[15 +: REG_AW];
  assign w_rs2 = bus.id_instr[20 +: REG_AW];
  assign w_unused_bits = ^{bus.id_instr[31:25], bus.id_instr[14:12]};

  assign w_hazard = r_valid && r_ctrl.mem_read && (r_rd != '0) && bus.id_valid &&
                    ((w_use_rs1 && (w_rs1 == r_rd)) || (w_use_rs2 && (w_rs2 == r_rd)));

  // A taken branch in EX kills the ID instruction, so it must not stall the front end.
  assign w_stall        = !bus.ex_flush && (bus.ex_hold || w_hazard);
  assign bus.pc_write   = !w_stall;
  assign bus.ifid_write = !w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl      <= CTRL_NOP;
      r_valid     <= 1'b0;
      r_rd        <= '0;
      r_illegal   <= 1'b0;
      r_stall_cnt <= '0;
    end else if (bus.ex_flush) begin
      r_ctrl  <= CTRL_NOP;
      r_valid <= 1'b0;
      r_rd    <= '0;
    end else if (!bus.ex_hold) begin
      if (w_hazard) begin
        r_ctrl  <= CTRL_NOP;
        r_valid <= 1'b0;
        r_rd    <= '0;
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else if (bus.id_valid) begin
        r_ctrl    <= w_ctrl;
        r_valid   <= 1'b1;
        r_rd      <= (w_ctrl.mem_write || w_ctrl.branch) ? '0 : bus.id_instr[7 +: REG_AW];
        r_illegal <= r_illegal | w_illegal;
      end else begin
        r_ctrl  <= CTRL_NOP;
        r_valid <= 1'b0;
        r_rd    <= '0;
      end
    end
  end

  assign bus.ex_valid      = r_valid;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_branch     = r_ctrl.branch;
  assign bus.ex_jump       = r_ctrl.jump;
  assign bus.ex_mem_read   = r_ctrl.mem_read;
  assign bus.ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign bus.ex_mem_write  = r_ctrl.mem_write;
  assign bus.ex_alu_src    = r_ctrl.alu_src;
  assign bus.ex_reg_write  = r_ctrl.reg_write;
  assign bus.ex_alu_op     = r_ctrl.alu_op;
  assign bus.ex_imm_sel    = r_ctrl.imm_sel;
  assign bus.illegal       = r_illegal;
  assign bus.stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: default-parameter instance plus a reduced instance (no jumps, 2-bit stall counter).
module tb_pipelined_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pipelined_control_unit_if #(.REG_AW(5), .CNT_W(16)) b();
  pipelined_control_unit_if #(.REG_AW(5), .CNT_W(2))  b2();

  pipelined_control_unit #(.REG_AW(5), .ENABLE_JUMP(1'b1), .ENABLE_ITYPE(1'b1), .CNT_W(16)) dut (
    .clk (clk), .rst_n (rst_n), .bus (b)
  );

  pipelined_control_unit #(.REG_AW(5), .ENABLE_JUMP(1'b0), .ENABLE_ITYPE(1'b1), .CNT_W(2)) dut2 (
    .clk (clk), .rst_n (rst_n), .bus (b2)
  );

  // {branch, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op[1:0], imm_sel[2:0]}
  logic [11:0] ctl1, ctl2;
  assign ctl1 = {b.ex_branch, b.ex_jump, b.ex_mem_read, b.ex_mem_to_reg, b.ex_mem_write,
                 b.ex_alu_src, b.ex_reg_write, b.ex_alu_op, b.ex_imm_sel};
  assign ctl2 = {b2.ex_branch, b2.ex_jump, b2.ex_mem_read, b2.ex_mem_to_reg, b2.ex_mem_write,
                 b2.ex_alu_src, b2.ex_reg_write, b2.ex_alu_op, b2.ex_imm_sel};

  localparam logic [31:0] I_R_X3   = 32'h000001B3;  // add x3,x0,x0
  localparam logic [31:0] I_ADDI4  = 32'h00000213;  // addi x4,x0,0
  localparam logic [31:0] I_LW_X5  = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] I_LW_X0  = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] I_ADD657 = 32'h00728333;  // add x6,x5,x7
  localparam logic [31:0] I_ADD600 = 32'h00000333;  // add x6,x0,x0
  localparam logic [31:0] I_LUI5   = 32'h000002B7;  // lui x5,0
  localparam logic [31:0] I_JAL1   = 32'h000000EF;  // jal x1,0
  localparam logic [31:0] I_BAD    = 32'h0000007F;

  logic [31:0] sw_instr [8] = '{32'h000001B3, 32'h00000213, 32'h0000A103, 32'h000002A3,
                                32'h00000363, 32'h000000EF, 32'h000003E7, 32'h00000437};
  logic [11:0] sw_ctl   [8] = '{12'b0000001_10_000, 12'b0000011_11_001, 12'b0011011_00_001,
                                12'b0000110_00_010, 12'b1000000_01_011, 12'b0100001_00_100,
                                12'b0100011_00_001, 12'b0000011_00_101};
  logic [4:0]  sw_rd    [8] = '{5'd3, 5'd4, 5'd2, 5'd0, 5'd0, 5'd1, 5'd7, 5'd8};
  string       sw_name  [8] = '{"R", "IALU", "LW", "SW", "BEQ", "JAL", "JALR", "LUI"};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr);
    b.id_valid = v;
    b.id_instr = instr;
  endtask

  task automatic drive2(input logic v, input logic [31:0] instr);
    b2.id_valid = v;
    b2.id_instr = instr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0); b.ex_flush = 1'b0; b.ex_hold = 1'b0;
    drive2(1'b0, 32'h0); b2.ex_flush = 1'b0; b2.ex_hold = 1'b0;
    #3;
    check("rst_ex_valid", b.ex_valid, 0);
    check("rst_ctl", ctl1, 0);
    check("rst_pc_write", b.pc_write, 1);
    check("rst_ifid_write", b.ifid_write, 1);
    check("rst_stall_count", b.stall_count, 0);
    check("rst_illegal", b.illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, sw_instr[i]);
      tick();
      check({"dec_ctl_", sw_name[i]}, ctl1, sw_ctl[i]);
      check({"dec_rd_", sw_name[i]}, b.ex_rd, sw_rd[i]);
      check({"dec_valid_", sw_name[i]}, b.ex_valid, 1);
    end

    drive(1'b0, I_R_X3);
    tick();
    check("invalid_bubble_valid", b.ex_valid, 0);
    check("invalid_bubble_ctl", ctl1, 0);

    // Load-use hazard
    drive(1'b1, I_LW_X5);
    tick();
    drive(1'b1, I_ADD657);
    #1;
    check("lu_pc_write", b.pc_write, 0);
    check("lu_ifid_write", b.ifid_write, 0);
    tick();
    check("lu_bubble", b.ex_valid, 0);
    check("lu_stall_count", b.stall_count, 1);
    check("lu_pc_write_after", b.pc_write, 1);
    tick();
    check("lu_add_valid", b.ex_valid, 1);
    check("lu_add_rd", b.ex_rd, 6);
    check("lu_add_ctl", ctl1, 12'b0000001_10_000);

    // LW x0 then use of x0
    drive(1'b1, I_LW_X0);
    tick();
    drive(1'b1, I_ADD600);
    #1;
    check("x0_pc_write", b.pc_write, 1);
    tick();
    check("x0_rd", b.ex_rd, 6);
    check("x0_stall_count", b.stall_count, 1);

    // LW x5 then LUI x5
    drive(1'b1, I_LW_X5);
    tick();
    drive(1'b1, I_LUI5);
    #1;
    check("lui_pc_write", b.pc_write, 1);
    tick();
    check("lui_valid", b.ex_valid, 1);
    check("lui_rd", b.ex_rd, 5);
    check("lui_stall_count", b.stall_count, 1);

    // Flush beats hazard
    drive(1'b1, I_LW_X5);
    tick();
    drive(1'b1, I_ADD657);
    b.ex_flush = 1'b1;
    #1;
    check("fl_pc_write", b.pc_write, 1);
    check("fl_ifid_write", b.ifid_write, 1);
    tick();
    b.ex_flush = 1'b0;
    check("fl_bubble", b.ex_valid, 0);
    check("fl_ctl", ctl1, 0);
    check("fl_stall_count", b.stall_count, 1);
    tick();
    check("fl_add_rd", b.ex_rd, 6);

    // Hold for 3 cycles
    drive(1'b1, I_ADDI4);
    tick();
    drive(1'b1, I_R_X3);
    b.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_pc_write", b.pc_write, 0);
      tick();
      check("hold_rd", b.ex_rd, 4);
      check("hold_ctl", ctl1, 12'b0000011_11_001);
    end
    b.ex_hold = 1'b0;
    tick();
    check("hold_release_rd", b.ex_rd, 3);

    // Illegal opcode: invalid slot must not set it, valid one must
    drive(1'b0, I_BAD);
    tick();
    check("illegal_invalid_slot", b.illegal, 0);
    drive(1'b1, I_BAD);
    tick();
    check("illegal_set", b.illegal, 1);
    check("illegal_ctl", ctl1, 0);
    drive(1'b1, I_R_X3);
    tick();
    check("illegal_sticky", b.illegal, 1);

    // Reduced instance: JAL illegal, 2-bit saturating counter
    drive(1'b0, 32'h0);
    drive2(1'b1, I_JAL1);
    tick();
    check("nj_jal_illegal", b2.illegal, 1);
    check("nj_jal_ctl", ctl2, 0);
    drive2(1'b1, I_R_X3);
    tick();
    tick();
    check("nj_illegal_sticky", b2.illegal, 1);
    for (int i = 0; i < 4; i++) begin
      drive2(1'b1, I_LW_X5);
      tick();
      drive2(1'b1, I_ADD657);
      tick();
      check("sat_stall_count", b2.stall_count, (i < 3) ? i + 1 : 3);
      tick();
    end
    drive2(1'b0, 32'h0);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, I_LW_X5);
    tick();
    drive(1'b1, I_ADD657);
    #1;
    check("pre_rst_valid", b.ex_valid, 1);
    check("pre_rst_pc_write", b.pc_write, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ex_valid", b.ex_valid, 0);
    check("arst_mem_read", b.ex_mem_read, 0);
    check("arst_rd", b.ex_rd, 0);
    check("arst_stall_count", b.stall_count, 0);
    check("arst_illegal", b.illegal, 0);
    check("arst_pc_write", b.pc_write, 1);
    check("arst_illegal2", b2.illegal, 0);
    check("arst_stall_count2", b2.stall_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
